// File: rtl/shift_line_ctrl.sv
// -----------------------------------------------------------------------------
// shift_line_ctrl
// Burst controller for an external DEPTH-stage shift register line. A tag line
// of DEPTH bits travels alongside the datapath so the controller knows which
// stages carry real words and which carry bubbles. A burst of iLen words is
// accepted from upstream (LOAD), the line is flushed with bubbles until the
// last real word has left (DRAIN), and the line is then cleared for one cycle
// (CLEAR) while oDone pulses.
//
// Ports
//   iClk       clock, all state on rising edge
//   iRst       synchronous active-high reset
//   iStart     burst start request (IDLE only)
//   iLen       burst word count, captured with iStart
//   iAbort     terminate current burst (LOAD/DRAIN only)
//   iInValid   upstream word present on the line input
//   oInReady   upstream word accepted when oInReady & iInValid
//   iOutReady  downstream accepts the line output
//   oOutValid  line output holds a real word
//   oShEn      shift enable for the line
//   oShClr     synchronous clear for the line
//   oFill      number of real words currently in the line
//   oBusy      high in every state except IDLE
//   oDone      one-cycle end-of-burst pulse
// -----------------------------------------------------------------------------
module shift_line_ctrl #(
  parameter int DEPTH = 8,
  parameter int CNTW  = 16,
  localparam int FW   = $clog2(DEPTH + 1)
) (
  input  logic            iClk,
  input  logic            iRst,
  input  logic            iStart,
  input  logic [CNTW-1:0] iLen,
  input  logic            iAbort,
  input  logic            iInValid,
  output logic            oInReady,
  input  logic            iOutReady,
  output logic            oOutValid,
  output logic            oShEn,
  output logic            oShClr,
  output logic [FW-1:0]   oFill,
  output logic            oBusy,
  output logic            oDone
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    CLEAR = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [DEPTH-1:0]  tag_q, tag_d;
  logic [CNTW-1:0]   remaining_q, remaining_d;
  logic [FW-1:0]     fill_q, fill_d;

  logic              out_valid_s;
  logic              stall_s;
  logic              shift_s;
  logic              in_ready_s;
  logic              accept_s;
  logic              handshake_s;

  // Handshake and shift qualifiers derived from the current tag line.
  always_comb begin
    out_valid_s = tag_q[DEPTH-1];
    stall_s     = out_valid_s & ~iOutReady;
    shift_s     = ((state_q == LOAD) || (state_q == DRAIN)) & ~stall_s;
    // No word is taken in a cycle that aborts the burst.
    in_ready_s  = (state_q == LOAD) & shift_s &
                  (remaining_q != {CNTW{1'b0}}) & ~iAbort;
    accept_s    = in_ready_s & iInValid;
    handshake_s = out_valid_s & iOutReady;
  end

  // Next-state logic for the FSM, tag line, word counter and fill counter.
  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    remaining_d = remaining_q;
    // Accept and output handshake cancel when they coincide; the fill can
    // never leave 0..DEPTH because it counts set bits of the tag line.
    fill_d      = fill_q + {{(FW-1){1'b0}}, accept_s}
                         - {{(FW-1){1'b0}}, handshake_s};

    if (shift_s) begin
      tag_d = {tag_q[DEPTH-2:0], accept_s};
    end else begin
      tag_d = tag_q;
    end

    if (accept_s) begin
      remaining_d = remaining_q - {{(CNTW-1){1'b0}}, 1'b1};
    end else begin
      remaining_d = remaining_q;
    end

    case (state_q)
      IDLE: begin
        if (iStart) begin
          remaining_d = iLen;
          if (iLen != {CNTW{1'b0}}) begin
            state_d = LOAD;
          end else begin
            state_d = CLEAR;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (iAbort) begin
          state_d = CLEAR;
        end else if (accept_s && (remaining_q == {{(CNTW-1){1'b0}}, 1'b1})) begin
          state_d = DRAIN;
        end else begin
          state_d = LOAD;
        end
      end
      DRAIN: begin
        if (iAbort) begin
          state_d = CLEAR;
        end else if (fill_d == {FW{1'b0}}) begin
          state_d = CLEAR;
        end else begin
          state_d = DRAIN;
        end
      end
      CLEAR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The line is emptied on the way into CLEAR so the CLEAR cycle itself
    // already shows an empty line, and stays empty while in CLEAR.
    if ((state_d == CLEAR) || (state_q == CLEAR)) begin
      tag_d  = {DEPTH{1'b0}};
      fill_d = {FW{1'b0}};
    end else begin
      tag_d  = tag_d;
      fill_d = fill_d;
    end
  end

  // State, tag line and counters register with synchronous reset.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q     <= IDLE;
      tag_q       <= {DEPTH{1'b0}};
      remaining_q <= {CNTW{1'b0}};
      fill_q      <= {FW{1'b0}};
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      remaining_q <= remaining_d;
      fill_q      <= fill_d;
    end
  end

  // Control outputs are forced low while reset is asserted so the line is
  // quiet even in the first reset cycle, before the state has been cleared.
  always_comb begin
    oInReady  = in_ready_s  & ~iRst;
    oOutValid = out_valid_s & ~iRst;
    oShEn     = shift_s     & ~iRst;
    oShClr    = (state_q == CLEAR) & ~iRst;
    oBusy     = (state_q != IDLE)  & ~iRst;
    oDone     = (state_q == CLEAR) & ~iRst;
    oFill     = fill_q;
  end

endmodule

// File: tb/tb_shift_line_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shift_line_ctrl
// Directed bench for shift_line_ctrl with DEPTH=4. Each burst is described by
// per-cycle input vectors and hand-computed per-cycle expected outputs
// (bit c of a vector = cycle c, cycle 0 is the IDLE cycle carrying iStart).
// -----------------------------------------------------------------------------
module tb_shift_line_ctrl;

  localparam int DEPTH = 4;
  localparam int CNTW  = 16;
  localparam int FW    = $clog2(DEPTH + 1);

  logic            iClk;
  logic            iRst;
  logic            iStart;
  logic [CNTW-1:0] iLen;
  logic            iAbort;
  logic            iInValid;
  logic            oInReady;
  logic            iOutReady;
  logic            oOutValid;
  logic            oShEn;
  logic            oShClr;
  logic [FW-1:0]   oFill;
  logic            oBusy;
  logic            oDone;

  int n_assert;
  int n_fail;

  shift_line_ctrl #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iStart    (iStart),
    .iLen      (iLen),
    .iAbort    (iAbort),
    .iInValid  (iInValid),
    .oInReady  (oInReady),
    .iOutReady (iOutReady),
    .oOutValid (oOutValid),
    .oShEn     (oShEn),
    .oShClr    (oShClr),
    .oFill     (oFill),
    .oBusy     (oBusy),
    .oDone     (oDone)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input int cyc,
                     input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge iClk);
    #1;
  endtask

  task automatic chk_all(input string name, input int cyc,
                         input logic ir, input logic ov, input logic se,
                         input logic cl, input logic bz, input logic dn);
    chk({name, ".oInReady"},  cyc, {31'd0, oInReady},  {31'd0, ir});
    chk({name, ".oOutValid"}, cyc, {31'd0, oOutValid}, {31'd0, ov});
    chk({name, ".oShEn"},     cyc, {31'd0, oShEn},     {31'd0, se});
    chk({name, ".oShClr"},    cyc, {31'd0, oShClr},    {31'd0, cl});
    chk({name, ".oBusy"},     cyc, {31'd0, oBusy},     {31'd0, bz});
    chk({name, ".oDone"},     cyc, {31'd0, oDone},     {31'd0, dn});
  endtask

  // Runs one burst of n cycles, starting right after a clock edge.
  task automatic run_seq(input string name, input int n, input logic [CNTW-1:0] len,
                         input logic [11:0] inv, input logic [11:0] ordy,
                         input logic [11:0] abt,
                         input logic [11:0] e_ir, input logic [11:0] e_ov,
                         input logic [11:0] e_se, input logic [11:0] e_cl,
                         input logic [11:0] e_bz, input logic [11:0] e_dn,
                         input int fc, input int fv);
    for (int c = 0; c < n; c++) begin
      iStart    = (c == 0);
      iLen      = (c == 0) ? len : 16'd0;
      iAbort    = abt[c];
      iInValid  = inv[c];
      iOutReady = ordy[c];
      #1;
      chk_all(name, c, e_ir[c], e_ov[c], e_se[c], e_cl[c], e_bz[c], e_dn[c]);
      if (c == fc) begin
        chk({name, ".oFill"}, c, {29'd0, oFill}, fv);
      end
      next_cycle();
    end
    iStart    = 1'b0;
    iAbort    = 1'b0;
    iInValid  = 1'b0;
    iOutReady = 1'b1;
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    iRst      = 1'b1;
    iStart    = 1'b0;
    iLen      = 16'd0;
    iAbort    = 1'b0;
    iInValid  = 1'b0;
    iOutReady = 1'b1;

    // Reset state
    next_cycle();
    next_cycle();
    chk_all("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.oFill", 0, {29'd0, oFill}, 32'd0);
    iRst = 1'b0;
    #1;
    chk_all("post_reset", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();

    // Basic burst of 3, no stall
    run_seq("burst3", 10, 16'd3,
            12'b1111_1111_1111, 12'b1111_1111_1111, 12'b0000_0000_0000,
            12'b0000_0000_1110, 12'b0000_1110_0000, 12'b0000_1111_1110,
            12'b0001_0000_0000, 12'b0001_1111_1110, 12'b0001_0000_0000,
            4, 3);

    // Downstream stall in cycle 5
    run_seq("stall", 11, 16'd3,
            12'b1111_1111_1111, 12'b1111_1101_1111, 12'b0000_0000_0000,
            12'b0000_0000_1110, 12'b0001_1110_0000, 12'b0001_1101_1110,
            12'b0010_0000_0000, 12'b0011_1111_1110, 12'b0010_0000_0000,
            5, 3);

    // Upstream bubble in cycle 1; abort in the IDLE start cycle is ignored
    run_seq("bubble", 10, 16'd2,
            12'b1111_1111_1101, 12'b1111_1111_1111, 12'b0000_0000_0001,
            12'b0000_0000_1110, 12'b0000_1100_0000, 12'b0000_1111_1110,
            12'b0001_0000_0000, 12'b0001_1111_1110, 12'b0001_0000_0000,
            5, 2);

    // Zero-length burst goes straight to CLEAR
    run_seq("len0", 3, 16'd0,
            12'b1111_1111_1111, 12'b1111_1111_1111, 12'b0000_0000_0000,
            12'b0000_0000_0000, 12'b0000_0000_0000, 12'b0000_0000_0000,
            12'b0000_0000_0010, 12'b0000_0000_0010, 12'b0000_0000_0010,
            1, 0);

    // Abort in cycle 2 of a 5-word burst
    run_seq("abort", 8, 16'd5,
            12'b1111_1111_1111, 12'b1111_1111_1111, 12'b0000_0000_0100,
            12'b0000_0000_0010, 12'b0000_0000_0000, 12'b0000_0000_0110,
            12'b0000_0000_1000, 12'b0000_0000_1110, 12'b0000_0000_1000,
            3, 0);

    // Reset held two cycles mid-LOAD, with iStart asserted during reset
    iStart = 1'b1; iLen = 16'd5; iInValid = 1'b1; iOutReady = 1'b1;
    next_cycle();
    iStart = 1'b0;
    #1;
    chk_all("rst_mid.load", 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    next_cycle();
    iRst = 1'b1;
    #1;
    chk_all("rst_mid.during", 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    iStart = 1'b1;
    iAbort = 1'b1;
    #1;
    chk_all("rst_mid.hold", 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_mid.oFill", 3, {29'd0, oFill}, 32'd0);
    next_cycle();
    iRst = 1'b0;
    iStart = 1'b0;
    iAbort = 1'b0;
    #1;
    chk_all("rst_mid.after", 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_mid.after_fill", 4, {29'd0, oFill}, 32'd0);
    next_cycle();

    // Normal operation resumes after reset
    run_seq("len0_again", 3, 16'd0,
            12'b0000_0000_0000, 12'b1111_1111_1111, 12'b0000_0000_0000,
            12'b0000_0000_0000, 12'b0000_0000_0000, 12'b0000_0000_0000,
            12'b0000_0000_0010, 12'b0000_0000_0010, 12'b0000_0000_0010,
            1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_line_ctrl.md
SHIFT_LINE_CTRL -- requirements
Module: shift_line_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of stages in the controlled shift_register; minimum 2.
REQ-002 SHALL have parameter CNTW, default 16: width of the burst-length field.
REQ-003 SHALL have port iClk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port iRst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port iStart, input, 1: burst start request, sampled only in IDLE.
REQ-006 SHALL have port iLen, input, CNTW: burst word count, captured with iStart.
REQ-007 SHALL have port iAbort, input, 1: terminate the current burst.
REQ-008 SHALL have port iInValid, input, 1: upstream word present on the shift_register iData.
REQ-009 SHALL have port oInReady, output, 1: word accepted this cycle when oInReady=1 and iInValid=1.
REQ-010 SHALL have port iOutReady, input, 1: downstream accepts the shift_register oData.
REQ-011 SHALL have port oOutValid, output, 1: shift_register oData holds a real word this cycle.
REQ-012 SHALL have port oShEn, output, 1: drives shift_register iEn.
REQ-013 SHALL have port oShClr, output, 1: drives shift_register iClr.
REQ-014 SHALL have port oFill, output, clog2(DEPTH+1): count of real words in the line.
REQ-015 SHALL have port oBusy, output, 1: high in every state except IDLE.
REQ-016 SHALL have port oDone, output, 1: one-cycle pulse marking end of burst.

Function
REQ-017 SHALL implement the states IDLE, LOAD, DRAIN and CLEAR.
REQ-018 SHALL keep a DEPTH-bit tag line mirroring the datapath: tag[0] loads on shift, tag[k] takes tag[k-1], and oOutValid=tag[DEPTH-1].
REQ-019 SHALL define stall = oOutValid & ~iOutReady, and assert oShEn = (state is LOAD or DRAIN) & ~stall.
REQ-020 SHALL, in LOAD, assert oInReady = oShEn & (remaining != 0); in all other states oInReady=0.
REQ-021 SHALL, on each shift, load tag[0] with 1 if a word is accepted and with 0 (bubble) otherwise.
REQ-022 SHALL keep oFill as a counter: +1 on accept, -1 on output handshake (oOutValid & iOutReady), net 0 when both occur in the same cycle.
REQ-023 SHALL make a word accepted in cycle t appear with oOutValid=1 in cycle t+DEPTH when no stall occurs; each stall cycle adds one cycle.
REQ-024 SHALL, in IDLE, on iStart: load remaining=iLen, then go to LOAD if iLen!=0, else to CLEAR.
REQ-025 SHALL decrement remaining on each accept; the accept that takes remaining to 0 moves the state to DRAIN.
REQ-026 SHALL, in DRAIN, shift bubbles and move to CLEAR once oFill reaches 0 (the next-state value of the fill counter is 0).
REQ-027 SHALL, in CLEAR, hold for exactly one cycle with oShClr=1, oShEn=0, all tags cleared and oDone=1, then return to IDLE.
REQ-028 SHALL, on iAbort in LOAD or DRAIN, move to CLEAR next cycle, accepting no word in the abort cycle.
REQ-029 SHALL ignore iAbort in IDLE and CLEAR.
REQ-030 SHALL ignore iStart outside IDLE.
REQ-031 SHALL have no accept, shift or output in the IDLE cycle that samples iStart.
REQ-032 SHALL make the oFill increment and decrement saturation-free; oFill never exceeds DEPTH by construction.

Reset
REQ-033 SHALL, with iRst=1 at a clock edge, force state=IDLE, tags=0, remaining=0 and oFill=0.
REQ-034 SHALL, during and after reset, hold oInReady, oOutValid, oShEn, oShClr, oBusy and oDone at 0.
REQ-035 SHALL give iRst priority over iStart and iAbort, including mid-burst, with no oDone pulse.

Verification (DEPTH=4)
REQ-036 SHALL pass: iRst high 2 cycles mid-LOAD -> next cycle all outputs 0, oFill=0, state IDLE.
REQ-037 SHALL pass: iStart at cycle 0, iLen=3, iInValid=1, iOutReady=1 -> oInReady=1 in cycles 1-3, oOutValid=1 in cycles 5-7, oShClr=1 and oDone=1 in cycle 8, oBusy=0 in cycle 9.
REQ-038 SHALL pass: as REQ-037 but iOutReady=0 in cycle 5 -> oShEn=0 and oInReady=0 in cycle 5, oOutValid held at 1, outputs in cycles 6-8, oDone in cycle 9.
REQ-039 SHALL pass: iLen=2 with iInValid=0 in cycle 1 -> words accepted in cycles 2-3, oOutValid=0 in cycle 5 (bubble), oOutValid=1 in cycles 6-7.
REQ-040 SHALL pass: iStart with iLen=0 -> cycle 1 in CLEAR with oDone=1, no oShEn.
REQ-041 SHALL pass: iAbort in cycle 2 of an iLen=5 burst -> cycle 3 in CLEAR with oShClr=1, oFill=0 and oDone=1, no further oOutValid.
